// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the TCM data-port arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } owner_e;

   typedef logic port_id_t;

   localparam port_id_t PORT0 = 1'b0;
   localparam port_id_t PORT1 = 1'b1;

   localparam int unsigned OUTSTANDING_MAX = 16;
   localparam int unsigned TAG_W_MAX       = 32;

   // One requester's view of the bus; tag is held at maximum width and
   // truncated to TAG_W at the output mux.
   typedef struct packed {
      logic [31:0]          addr;
      logic [31:0]          data;
      logic                 rd;
      logic [3:0]           wr;
      logic                 cacheable;
      logic [TAG_W_MAX-1:0] tag;
      logic                 flush;
      logic                 invalidate;
      logic                 writeback;
   } req_t;

   function automatic logic req_valid(input req_t r);
      return r.rd | (|r.wr) | r.flush | r.invalidate | r.writeback;
   endfunction

endpackage

// File: rtl/dmem_arb_src_fifo.sv
// Outstanding-source FIFO: remembers which port issued each accepted
// request so in-order responses can be routed back.
module dmem_arb_src_fifo
   import dmem_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  port_id_t               push_id_i,
   input  logic                   pop_i,
   output port_id_t               head_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   port_id_t        r_mem [DEPTH];
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;

   assign full_o  = (r_count == CW'(DEPTH));
   assign empty_o = (r_count == '0);
   assign count_o = r_count;
   assign head_o  = r_mem[r_rptr];
   assign w_push  = push_i & ~full_o;
   assign w_pop   = pop_i & ~empty_o;

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= PORT0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= push_id_i;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the TCM data port: port 0 = core, port 1 =
// loader/debug. Round-robin with owner lock, in-order response routing.
// Optional macro DMEM_ARB_PRIO_EN adds m1_prio_i (port 1 wins contention).
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned OUTSTANDING = 4,
   parameter int unsigned TAG_W       = 11
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      m0_addr_i,
   input  logic [31:0]      m0_data_wr_i,
   input  logic             m0_rd_i,
   input  logic [3:0]       m0_wr_i,
   input  logic             m0_cacheable_i,
   input  logic [TAG_W-1:0] m0_req_tag_i,
   input  logic             m0_flush_i,
   input  logic             m0_invalidate_i,
   input  logic             m0_writeback_i,
   output logic             m0_accept_o,
   output logic             m0_ack_o,
   output logic             m0_error_o,
   output logic [31:0]      m0_data_rd_o,
   output logic [TAG_W-1:0] m0_resp_tag_o,
   input  logic [31:0]      m1_addr_i,
   input  logic [31:0]      m1_data_wr_i,
   input  logic             m1_rd_i,
   input  logic [3:0]       m1_wr_i,
   input  logic [TAG_W-1:0] m1_req_tag_i,
   output logic             m1_accept_o,
   output logic             m1_ack_o,
   output logic             m1_error_o,
   output logic [31:0]      m1_data_rd_o,
   output logic [TAG_W-1:0] m1_resp_tag_o,
   output logic [31:0]      mem_d_addr_o,
   output logic [31:0]      mem_d_data_wr_o,
   output logic             mem_d_rd_o,
   output logic [3:0]       mem_d_wr_o,
   output logic             mem_d_cacheable_o,
   output logic [TAG_W-1:0] mem_d_req_tag_o,
   output logic             mem_d_flush_o,
   output logic             mem_d_invalidate_o,
   output logic             mem_d_writeback_o,
   input  logic             mem_d_accept_i,
   input  logic             mem_d_ack_i,
   input  logic             mem_d_error_i,
   input  logic [31:0]      mem_d_data_rd_i,
   input  logic [TAG_W-1:0] mem_d_resp_tag_i,
`ifdef DMEM_ARB_PRIO_EN
   input  logic             m1_prio_i,
`endif
   output logic             unexp_ack_o
);

   localparam int unsigned CW = $clog2(OUTSTANDING) + 1;

   owner_e          r_state;
   owner_e          w_state_next;
   port_id_t        r_rr;
   port_id_t        w_rr_next;
   logic            r_unexp;

   req_t            w_m0;
   req_t            w_m1;
   req_t            w_sel;
   req_t            w_out;
   logic            w_req0;
   logic            w_req1;
   port_id_t        w_sel_id;
   logic            w_sel_valid;
   logic            w_present;
   logic            w_push;
   logic            w_pop;
   logic            w_prio;
   port_id_t        w_head;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic            w_full;
   logic [CW-1:0]   w_count;

`ifdef DMEM_ARB_PRIO_EN
   assign w_prio = m1_prio_i;
`else
   assign w_prio = 1'b0;
`endif

   // Pack each requester's fields into a common request record.
   always_comb begin
      w_m0            = '0;
      w_m0.addr       = m0_addr_i;
      w_m0.data       = m0_data_wr_i;
      w_m0.rd         = m0_rd_i;
      w_m0.wr         = m0_wr_i;
      w_m0.cacheable  = m0_cacheable_i;
      w_m0.tag        = TAG_W_MAX'(m0_req_tag_i);
      w_m0.flush      = m0_flush_i;
      w_m0.invalidate = m0_invalidate_i;
      w_m0.writeback  = m0_writeback_i;
      w_m1            = '0;
      w_m1.addr       = m1_addr_i;
      w_m1.data       = m1_data_wr_i;
      w_m1.rd         = m1_rd_i;
      w_m1.wr         = m1_wr_i;
      w_m1.tag        = TAG_W_MAX'(m1_req_tag_i);
   end

   assign w_req0 = req_valid(w_m0);
   assign w_req1 = req_valid(w_m1);
   // Count MSB is set only at DEPTH occupancy (power-of-two depth).
   assign w_full = w_fifo_full & w_count[CW-1];

   // Owner state register and round-robin pointer.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= IDLE;
         r_rr    <= PORT0;
      end else begin
         r_state <= w_state_next;
         r_rr    <= w_rr_next;
      end
   end

   // Winner selection, bus presentation and owner next-state.
   always_comb begin
      w_sel_id     = PORT0;
      w_sel_valid  = 1'b0;
      w_state_next = r_state;
      w_rr_next    = r_rr;
      unique case (r_state)
         IDLE: begin
            if (w_req0 && w_req1) w_sel_id = w_prio ? PORT1 : r_rr;
            else if (w_req1)      w_sel_id = PORT1;
            else                  w_sel_id = PORT0;
            w_sel_valid = w_req0 | w_req1;
         end
         OWN0: begin
            w_sel_id    = PORT0;
            w_sel_valid = w_req0;
         end
         OWN1: begin
            w_sel_id    = PORT1;
            w_sel_valid = w_req1;
         end
         default: begin
            w_sel_id    = PORT0;
            w_sel_valid = 1'b0;
         end
      endcase

      w_present = rst_i & ~w_full & w_sel_valid;
      w_push    = w_present & mem_d_accept_i;

      unique case (r_state)
         IDLE: begin
            if (w_present) begin
               if (mem_d_accept_i) begin
                  if (!w_prio) w_rr_next = ~w_sel_id;
               end else begin
                  w_state_next = (w_sel_id == PORT1) ? OWN1 : OWN0;
               end
            end
         end
         OWN0, OWN1: begin
            // A dropped request releases the lock even while full.
            if (!w_sel_valid) begin
               w_state_next = IDLE;
            end else if (w_push) begin
               w_state_next = IDLE;
               w_rr_next    = ~w_sel_id;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign w_sel = (w_sel_id == PORT1) ? w_m1 : w_m0;
   assign w_out = w_present ? w_sel : '0;

   assign mem_d_addr_o       = w_out.addr;
   assign mem_d_data_wr_o    = w_out.data;
   assign mem_d_rd_o         = w_out.rd;
   assign mem_d_wr_o         = w_out.wr;
   assign mem_d_cacheable_o  = w_out.cacheable;
   assign mem_d_req_tag_o    = w_out.tag[TAG_W-1:0];
   assign mem_d_flush_o      = w_out.flush;
   assign mem_d_invalidate_o = w_out.invalidate;
   assign mem_d_writeback_o  = w_out.writeback;

   assign m0_accept_o = w_push & (w_sel_id == PORT0);
   assign m1_accept_o = w_push & (w_sel_id == PORT1);

   dmem_arb_src_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_src_fifo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .push_i    (w_push),
      .push_id_i (w_sel_id),
      .pop_i     (w_pop),
      .head_o    (w_head),
      .full_o    (w_fifo_full),
      .empty_o   (w_fifo_empty),
      .count_o   (w_count)
   );

   assign w_pop = mem_d_ack_i & ~w_fifo_empty;

   assign m0_ack_o      = w_pop & (w_head == PORT0);
   assign m0_error_o    = m0_ack_o & mem_d_error_i;
   assign m0_data_rd_o  = m0_ack_o ? mem_d_data_rd_i : '0;
   assign m0_resp_tag_o = m0_ack_o ? mem_d_resp_tag_i : '0;
   assign m1_ack_o      = w_pop & (w_head == PORT1);
   assign m1_error_o    = m1_ack_o & mem_d_error_i;
   assign m1_data_rd_o  = m1_ack_o ? mem_d_data_rd_i : '0;
   assign m1_resp_tag_o = m1_ack_o ? mem_d_resp_tag_i : '0;

   // Sticky flag for a response arriving with nothing outstanding.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                          r_unexp <= 1'b0;
      else if (mem_d_ack_i && w_fifo_empty) r_unexp <= 1'b1;
   end

   assign unexp_ack_o = r_unexp;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter (default build).
module tb_dmem_port_arbiter;

   localparam int unsigned TAG_W = 11;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [31:0]      m0_addr_i, m0_data_wr_i, m1_addr_i, m1_data_wr_i;
   logic             m0_rd_i, m1_rd_i, m0_cacheable_i;
   logic [3:0]       m0_wr_i, m1_wr_i;
   logic [TAG_W-1:0] m0_req_tag_i, m1_req_tag_i;
   logic             m0_flush_i, m0_invalidate_i, m0_writeback_i;
   logic             m0_accept_o, m0_ack_o, m0_error_o;
   logic [31:0]      m0_data_rd_o;
   logic [TAG_W-1:0] m0_resp_tag_o;
   logic             m1_accept_o, m1_ack_o, m1_error_o;
   logic [31:0]      m1_data_rd_o;
   logic [TAG_W-1:0] m1_resp_tag_o;
   logic [31:0]      mem_d_addr_o, mem_d_data_wr_o;
   logic             mem_d_rd_o, mem_d_cacheable_o;
   logic [3:0]       mem_d_wr_o;
   logic [TAG_W-1:0] mem_d_req_tag_o;
   logic             mem_d_flush_o, mem_d_invalidate_o, mem_d_writeback_o;
   logic             mem_d_accept_i, mem_d_ack_i, mem_d_error_i;
   logic [31:0]      mem_d_data_rd_i;
   logic [TAG_W-1:0] mem_d_resp_tag_i;
   logic             unexp_ack_o;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk_i = ~clk_i;

   dmem_port_arbiter #(
      .OUTSTANDING (4),
      .TAG_W       (TAG_W)
   ) dut (
      .clk_i (clk_i), .rst_i (rst_i),
      .m0_addr_i (m0_addr_i), .m0_data_wr_i (m0_data_wr_i), .m0_rd_i (m0_rd_i),
      .m0_wr_i (m0_wr_i), .m0_cacheable_i (m0_cacheable_i), .m0_req_tag_i (m0_req_tag_i),
      .m0_flush_i (m0_flush_i), .m0_invalidate_i (m0_invalidate_i), .m0_writeback_i (m0_writeback_i),
      .m0_accept_o (m0_accept_o), .m0_ack_o (m0_ack_o), .m0_error_o (m0_error_o),
      .m0_data_rd_o (m0_data_rd_o), .m0_resp_tag_o (m0_resp_tag_o),
      .m1_addr_i (m1_addr_i), .m1_data_wr_i (m1_data_wr_i), .m1_rd_i (m1_rd_i),
      .m1_wr_i (m1_wr_i), .m1_req_tag_i (m1_req_tag_i),
      .m1_accept_o (m1_accept_o), .m1_ack_o (m1_ack_o), .m1_error_o (m1_error_o),
      .m1_data_rd_o (m1_data_rd_o), .m1_resp_tag_o (m1_resp_tag_o),
      .mem_d_addr_o (mem_d_addr_o), .mem_d_data_wr_o (mem_d_data_wr_o), .mem_d_rd_o (mem_d_rd_o),
      .mem_d_wr_o (mem_d_wr_o), .mem_d_cacheable_o (mem_d_cacheable_o), .mem_d_req_tag_o (mem_d_req_tag_o),
      .mem_d_flush_o (mem_d_flush_o), .mem_d_invalidate_o (mem_d_invalidate_o),
      .mem_d_writeback_o (mem_d_writeback_o),
      .mem_d_accept_i (mem_d_accept_i), .mem_d_ack_i (mem_d_ack_i), .mem_d_error_i (mem_d_error_i),
      .mem_d_data_rd_i (mem_d_data_rd_i), .mem_d_resp_tag_i (mem_d_resp_tag_i),
`ifdef DMEM_ARB_PRIO_EN
      .m1_prio_i (1'b0),
`endif
      .unexp_ack_o (unexp_ack_o)
   );

   // Inputs change 1 time unit after the rising edge; checks occur mid-cycle.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic clear_inputs();
      m0_addr_i = '0; m0_data_wr_i = '0; m0_rd_i = 1'b0; m0_wr_i = '0;
      m0_cacheable_i = 1'b0; m0_req_tag_i = '0;
      m0_flush_i = 1'b0; m0_invalidate_i = 1'b0; m0_writeback_i = 1'b0;
      m1_addr_i = '0; m1_data_wr_i = '0; m1_rd_i = 1'b0; m1_wr_i = '0; m1_req_tag_i = '0;
      mem_d_accept_i = 1'b0; mem_d_ack_i = 1'b0; mem_d_error_i = 1'b0;
      mem_d_data_rd_i = '0; mem_d_resp_tag_i = '0;
   endtask

   task automatic do_reset();
      tick();
      clear_inputs();
      rst_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_i = 1'b0;
      tick();
      m0_rd_i = 1'b1; m0_addr_i = 32'h44; mem_d_accept_i = 1'b1; mem_d_ack_i = 1'b1;
      mid();
      n_total++; if (mem_d_rd_o !== 1'b0) $display("FAIL reset_rd: got %b want 0", mem_d_rd_o); else n_pass++;
      n_total++; if (mem_d_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_d_addr_o); else n_pass++;
      n_total++; if (m0_accept_o !== 1'b0) $display("FAIL reset_accept: got %b want 0", m0_accept_o); else n_pass++;
      n_total++; if ({m0_ack_o, m1_ack_o} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {m0_ack_o, m1_ack_o}); else n_pass++;
      n_total++; if (unexp_ack_o !== 1'b0) $display("FAIL reset_unexp: got %b want 0", unexp_ack_o); else n_pass++;
      tick();
      clear_inputs();
      rst_i = 1'b1;
   endtask

   task automatic test_single_read();
      do_reset();
      tick();
      m0_rd_i = 1'b1; m0_addr_i = 32'h100; m0_req_tag_i = 11'h005; mem_d_accept_i = 1'b1;
      mid();
      n_total++; if (m0_accept_o !== 1'b1) $display("FAIL single_accept: got %b want 1", m0_accept_o); else n_pass++;
      n_total++; if (mem_d_addr_o !== 32'h100 || mem_d_rd_o !== 1'b1 || mem_d_req_tag_o !== 11'h005)
         $display("FAIL single_fwd: got addr %h rd %b tag %h want 100 1 005", mem_d_addr_o, mem_d_rd_o, mem_d_req_tag_o);
      else n_pass++;
      tick();
      clear_inputs();
      tick();
      mem_d_ack_i = 1'b1; mem_d_data_rd_i = 32'hDEADBEEF; mem_d_resp_tag_i = 11'h005;
      mid();
      n_total++; if (m0_ack_o !== 1'b1 || m0_data_rd_o !== 32'hDEADBEEF || m0_resp_tag_o !== 11'h005)
         $display("FAIL single_resp: got ack %b data %h tag %h want 1 deadbeef 005", m0_ack_o, m0_data_rd_o, m0_resp_tag_o);
      else n_pass++;
      n_total++; if (m1_ack_o !== 1'b0 || m1_data_rd_o !== 32'h0) $display("FAIL single_m1_quiet: got ack %b data %h want 0 0", m1_ack_o, m1_data_rd_o); else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_contention();
      logic exp0;
      do_reset();
      for (int i = 0; i <= 6; i++) begin
         tick();
         m0_rd_i = (i < 6); m0_addr_i = 32'hA0;
         m1_rd_i = (i < 6); m1_addr_i = 32'hB0;
         mem_d_accept_i = (i < 6);
         mem_d_ack_i = (i >= 1);
         mem_d_data_rd_i = 32'h1000 + i;
         mid();
         if (i < 6) begin
            exp0 = (i % 2 == 0);
            n_total++; if ({m0_accept_o, m1_accept_o} !== {exp0, ~exp0})
               $display("FAIL rr_grant[%0d]: got %b want %b", i, {m0_accept_o, m1_accept_o}, {exp0, ~exp0});
            else n_pass++;
            n_total++; if (mem_d_addr_o !== (exp0 ? 32'hA0 : 32'hB0))
               $display("FAIL rr_addr[%0d]: got %h want %h", i, mem_d_addr_o, exp0 ? 32'hA0 : 32'hB0);
            else n_pass++;
         end
         if (i >= 1) begin
            exp0 = ((i - 1) % 2 == 0);
            n_total++; if ({m0_ack_o, m1_ack_o} !== {exp0, ~exp0})
               $display("FAIL rr_ack[%0d]: got %b want %b", i, {m0_ack_o, m1_ack_o}, {exp0, ~exp0});
            else n_pass++;
            n_total++; if ((exp0 ? m0_data_rd_o : m1_data_rd_o) !== 32'h1000 + i)
               $display("FAIL rr_data[%0d]: got %h want %h", i, exp0 ? m0_data_rd_o : m1_data_rd_o, 32'h1000 + i);
            else n_pass++;
         end
      end
      tick();
      clear_inputs();
   endtask

   task automatic test_lock();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         m0_rd_i = 1'b1; m0_addr_i = 32'h200; mem_d_accept_i = 1'b0;
         m1_rd_i = (i > 0); m1_addr_i = 32'h300;
         mid();
         n_total++; if (mem_d_addr_o !== 32'h200) $display("FAIL lock_addr[%0d]: got %h want 200", i, mem_d_addr_o); else n_pass++;
         n_total++; if ({m0_accept_o, m1_accept_o} !== 2'b00) $display("FAIL lock_noacc[%0d]: got %b want 00", i, {m0_accept_o, m1_accept_o}); else n_pass++;
      end
      tick();
      mem_d_accept_i = 1'b1;
      mid();
      n_total++; if (m0_accept_o !== 1'b1 || m1_accept_o !== 1'b0 || mem_d_addr_o !== 32'h200)
         $display("FAIL lock_release: got acc %b%b addr %h want 10 200", m0_accept_o, m1_accept_o, mem_d_addr_o);
      else n_pass++;
      tick();
      m0_addr_i = 32'h204;
      mid();
      n_total++; if (m1_accept_o !== 1'b1 || m0_accept_o !== 1'b0 || mem_d_addr_o !== 32'h300)
         $display("FAIL lock_next: got acc %b%b addr %h want 01 300", m0_accept_o, m1_accept_o, mem_d_addr_o);
      else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         tick();
         m0_rd_i = 1'b1; m0_addr_i = 32'h400 + 4 * i; mem_d_accept_i = 1'b1;
         mid();
         n_total++; if (m0_accept_o !== 1'b1) $display("FAIL full_fill[%0d]: got %b want 1", i, m0_accept_o); else n_pass++;
      end
      tick();
      m0_addr_i = 32'h410;
      mid();
      n_total++; if (mem_d_rd_o !== 1'b0 || m0_accept_o !== 1'b0 || mem_d_addr_o !== 32'h0)
         $display("FAIL full_block: got rd %b acc %b addr %h want 0 0 0", mem_d_rd_o, m0_accept_o, mem_d_addr_o);
      else n_pass++;
      tick();
      mem_d_ack_i = 1'b1; mem_d_data_rd_i = 32'h0BAD_F00D;
      mid();
      n_total++; if (mem_d_rd_o !== 1'b0 || m0_accept_o !== 1'b0)
         $display("FAIL full_pop_same: got rd %b acc %b want 0 0", mem_d_rd_o, m0_accept_o);
      else n_pass++;
      n_total++; if (m0_ack_o !== 1'b1 || m0_data_rd_o !== 32'h0BAD_F00D)
         $display("FAIL full_ack: got ack %b data %h want 1 0badf00d", m0_ack_o, m0_data_rd_o);
      else n_pass++;
      tick();
      mem_d_ack_i = 1'b0;
      mid();
      n_total++; if (mem_d_rd_o !== 1'b1 || m0_accept_o !== 1'b1 || mem_d_addr_o !== 32'h410)
         $display("FAIL full_resume: got rd %b acc %b addr %h want 1 1 410", mem_d_rd_o, m0_accept_o, mem_d_addr_o);
      else n_pass++;
      tick();
      clear_inputs();
   endtask

   task automatic test_unexp_ack();
      do_reset();
      tick();
      mem_d_ack_i = 1'b1; mem_d_data_rd_i = 32'h55; mem_d_resp_tag_i = 11'h7;
      mid();
      n_total++; if ({m0_ack_o, m1_ack_o} !== 2'b00 || m0_data_rd_o !== 32'h0)
         $display("FAIL unexp_noack: got ack %b data %h want 00 0", {m0_ack_o, m1_ack_o}, m0_data_rd_o);
      else n_pass++;
      tick();
      mem_d_ack_i = 1'b0;
      mid();
      n_total++; if (unexp_ack_o !== 1'b1) $display("FAIL unexp_set: got %b want 1", unexp_ack_o); else n_pass++;
      tick(); tick(); tick();
      n_total++; if (unexp_ack_o !== 1'b1) $display("FAIL unexp_sticky: got %b want 1", unexp_ack_o); else n_pass++;
      rst_i = 1'b0;
      #1;
      n_total++; if (unexp_ack_o !== 1'b0) $display("FAIL unexp_clear: got %b want 0", unexp_ack_o); else n_pass++;
      tick();
      rst_i = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      tick();
      m1_wr_i = 4'hF; m1_addr_i = 32'h500; mem_d_accept_i = 1'b1;
      mid();
      n_total++; if (m1_accept_o !== 1'b1 || mem_d_wr_o !== 4'hF) $display("FAIL mid_wr: got acc %b wr %h want 1 f", m1_accept_o, mem_d_wr_o); else n_pass++;
      tick();
      m1_wr_i = '0; m1_rd_i = 1'b1; m1_addr_i = 32'h504;
      mid();
      n_total++; if (m1_accept_o !== 1'b1) $display("FAIL mid_rd: got %b want 1", m1_accept_o); else n_pass++;
      tick();
      m1_addr_i = 32'h508; mem_d_accept_i = 1'b0;
      tick();
      m0_rd_i = 1'b1; m0_addr_i = 32'h600;
      mid();
      n_total++; if (mem_d_addr_o !== 32'h508 || m0_accept_o !== 1'b0)
         $display("FAIL mid_own1: got addr %h acc0 %b want 508 0", mem_d_addr_o, m0_accept_o);
      else n_pass++;
      rst_i = 1'b0; mem_d_accept_i = 1'b1; mem_d_ack_i = 1'b1; mem_d_data_rd_i = 32'h77;
      #1;
      n_total++; if (mem_d_rd_o !== 1'b0 || mem_d_addr_o !== 32'h0 || {m0_accept_o, m1_accept_o} !== 2'b00)
         $display("FAIL mid_rst_req: got rd %b addr %h acc %b%b want 0 0 00", mem_d_rd_o, mem_d_addr_o, m0_accept_o, m1_accept_o);
      else n_pass++;
      n_total++; if ({m0_ack_o, m1_ack_o} !== 2'b00 || m1_data_rd_o !== 32'h0)
         $display("FAIL mid_rst_ack: got ack %b%b data %h want 00 0", m0_ack_o, m1_ack_o, m1_data_rd_o);
      else n_pass++;
      tick();
      rst_i = 1'b1; mem_d_ack_i = 1'b0;
      mid();
      n_total++; if ({m0_accept_o, m1_accept_o} !== 2'b10 || mem_d_addr_o !== 32'h600)
         $display("FAIL mid_after: got acc %b%b addr %h want 10 600", m0_accept_o, m1_accept_o, mem_d_addr_o);
      else n_pass++;
      tick();
      clear_inputs();
   endtask

   initial begin
      rst_i = 1'b0;
      clear_inputs();
      test_reset();
      test_single_read();
      test_contention();
      test_lock();
      test_full();
      test_unexp_ack();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single TCM data port between two requesters: port 0 = core data port, port 1 = loader/debug master (instruction image load, memory peek/poke).
- Sits between riscv_core's mem_d_* outputs and tcm_mem's mem_d_* inputs.
- Round-robin arbitration with an owner lock that holds until the request is accepted.
- Routes in-order responses back to the issuing port through an outstanding-source FIFO.

Parameters:
- OUTSTANDING, 4, maximum accepted-but-unacked requests; power of two, 2..16.
- TAG_W, 11, request/response tag width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- m0_addr_i/m1_addr_i  in  32  request address
- m0_data_wr_i/m1_data_wr_i  in  32  write data
- m0_rd_i/m1_rd_i  in  1  read request
- m0_wr_i/m1_wr_i  in  4  byte write strobes
- m0_cacheable_i  in  1  forwarded when port 0 owns the bus; 0 for port 1
- m0_req_tag_i/m1_req_tag_i  in  TAG_W  request tag
- m0_flush_i, m0_invalidate_i, m0_writeback_i  in  1  port-0 cache commands; each counts as a request
- m0_accept_o/m1_accept_o  out  1  request accepted this cycle
- m0_ack_o/m1_ack_o  out  1  response valid
- m0_error_o/m1_error_o  out  1  response error
- m0_data_rd_o/m1_data_rd_o  out  32  read data
- m0_resp_tag_o/m1_resp_tag_o  out  TAG_W  response tag
- mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o, mem_d_cacheable_o, mem_d_req_tag_o, mem_d_flush_o, mem_d_invalidate_o, mem_d_writeback_o  out  as above  to TCM
- mem_d_accept_i, mem_d_ack_i, mem_d_error_i, mem_d_data_rd_i, mem_d_resp_tag_i  in  as above  from TCM
- unexp_ack_o  out  1  sticky: ack received with FIFO empty

Behaviour:
- Reset (rst_i low, asynchronous):
  - FIFO empty; owner lock cleared; round-robin pointer = port 0; unexp_ack_o = 0.
  - All outputs are combinational from state and inputs, so every accept, ack and mem_d_* strobe is 0 while in reset.
- Request definition: reqN = rdN | (|wrN); port 0 additionally ORs in flush, invalidate and writeback.
- Owner state machine, states IDLE, OWN0, OWN1:
  - IDLE, FIFO not full:
    - Pick a requester: a single request wins; on two requests the port the RR pointer indicates wins.
    - The winner's fields drive mem_d_* in the same cycle (zero-cycle forward).
    - If mem_d_accept_i=1: push the winner ID, set the RR pointer to the other port, stay IDLE.
    - Else: go to OWNn.
  - OWNn: mux stays fixed on port n regardless of the other port.
    - On mem_d_accept_i: push n, RR pointer := other port, go to IDLE.
    - If port n drops its request (protocol violation): go to IDLE, no push.
  - FIFO full: no mem_d_* strobes are driven (all 0) and no accept is given. The OWN state is retained. A pop in the same cycle does not unblock; presentation resumes the next cycle.
- m0_accept_o / m1_accept_o = mem_d_accept_i & strobe-presented & owner==n.
- Response path:
  - On mem_d_ack_i, pop the FIFO head h.
  - Assert mh_ack_o with data, error and resp_tag passed through combinationally; the other port's outputs are 0.
  - Ack with FIFO empty: no port acked; unexp_ack_o set until reset.
- Simultaneous push and pop (not full): both occur; count unchanged.
- Throughput: one request per cycle when accepted in IDLE; no bubble between alternating ports.

Optional Feature:
- Macro DMEM_ARB_PRIO_EN.
- Defined: adds input m1_prio_i (1 bit).
  - When high, port 1 wins all IDLE contention and the RR pointer is not updated.
  - The owner lock is still honoured.
- Undefined: pure round-robin; port absent.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - owner_e enum (IDLE, OWN0, OWN1)
  - port ID type (1 bit)
  - OUTSTANDING_MAX constant
  - req_t struct (addr, data, rd, wr, tag, cmd bits)
- One sub-module: dmem_arb_src_fifo. Synchronous FIFO of 1-bit IDs, depth OUTSTANDING, with full/empty flags and a count of width log2(OUTSTANDING)+1.

Test Plan:
- Single read: m0_rd_i=1, addr 0x100, tag 0x005, TCM accepts at once and acks 2 cycles later with data 0xDEADBEEF -> m0_accept_o=1 in the request cycle; m0_ack_o=1, m0_data_rd_o=0xDEADBEEF, m0_resp_tag_o=0x005; m1_ack_o stays 0.
- Contention: both ports request continuously for 6 cycles, TCM always accepting -> grants 0,1,0,1,0,1; acks routed to the matching port in the same order.
- Lock: TCM holds mem_d_accept_i=0 for 3 cycles while port 0 is the owner and port 1 raises a request -> mem_d_addr_o stays port 0's address until accept; port 1 is granted the next cycle.
- Full: OUTSTANDING=4, 4 accepted, no acks -> 5th request sees mem_d_rd_o=0 and no accept; one ack -> 5th presented on the following cycle.
- Unexpected ack: mem_d_ack_i pulse with FIFO empty -> no port ack; unexp_ack_o=1 until rst_i low.
- Reset mid-operation: rst_i low with 2 outstanding and OWN1 -> all outputs 0 immediately; after release, a port 0 request is granted first.
